seg_result_display: RTL and testbench
=====================================

Name: seg_result_display

Overview:
- Output-side counterpart of the keypad/data-input path of the OpenMIPS SoPC.
- When the CPU asserts its result-valid strobe, the block captures the 32-bit result and converts it to 4-digit decimal with a sequential double-dabble.
- It then drives a time-multiplexed 4-digit common-anode 7-segment display.
- It runs on the 10 kHz board clock, not the divided CPU clock.

Parameters:
- DIGITS, 4, number of display digits scanned; only 4 is supported.
- SCAN_DIV, 25, clk cycles each digit stays enabled before the scan advances.
- BIN_W, 16, number of binary bits fed to the BCD converter; equals the number of shift iterations.

Ports:
- clk  input  1  board clock (10 kHz).
- rst  input  1  asynchronous, active-low reset.
- res_i  input  32  CPU result word, unsigned.
- out_i  input  1  CPU result-valid level; a 0→1 transition requests a new display value.
- seg_o  output  8  segment drive, active-low, bit7=dp (always 1), bits6..0=g..a.
- an_o  output  4  digit enable, active-low, one-hot-zero; bit0 = units digit.
- busy_o  output  1  conversion in progress.
- ovf_o  output  1  last accepted value exceeded 9999.

Behaviour:
- Asynchronous reset (rst=0), while asserted:
  - Display digit registers = 0, ovf_o=0, busy_o=0.
  - Scan index=0, scan counter=0, an_o=4'b1110, seg_o=8'hC0 (shows "0").
  - Edge-detect register=0, pending flag cleared.
  - FSM in IDLE.
- Request detection: out_i is registered once; req = out_i & ~out_q. An out_i held high gives exactly one request.
- FSM states are IDLE, SHIFT and DONE.
- IDLE, on req or pending:
  - Load the shift register with res_i[15:0] (or pend_val if pending).
  - Set ovf_nxt = (value > 32'd9999); the compare is on the full 32-bit value.
  - Clear the BCD nibbles, set iter=0, set busy_o=1, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd,bin} shifts left 1.
  - iter increments. After iteration BIN_W-1, go to DONE.
- DONE:
  - Copy the 4 low BCD nibbles to the display registers and ovf_nxt to ovf_o.
  - busy_o=0, go to IDLE.
- Latency: req sampled at edge N.
  - Load at N; shifts at N+1..N+16; display and ovf_o update at edge N+17, where busy_o also falls.
  - Total: busy high for 17 cycles.
- A request in IDLE while pending=0 starts at once. A request accepted on the same edge DONE completes is held as pending and starts on the next cycle.
- Request while busy:
  - Set pending and capture res_i into pend_val; latest wins, one-deep.
  - pending clears when its conversion loads.
  - The display never shows an intermediate value.
- Conversion width:
  - Values >9999 still run the full 17 cycles, so timing is deterministic.
  - The display shows "----" (seg 8'hBF on every digit) while ovf_o=1.
- Scan:
  - The counter runs 0..SCAN_DIV-1. On wrap, the index advances 0→1→2→3→0.
  - an_o drives low only the indexed digit.
  - seg_o is combinational from the index and the registered digits; no overlap between digits.
- Segment codes (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Dash=BF, blank=FF.
- Leading-zero blanking: any digit above the most significant nonzero digit shows FF. Digit 0 is never blanked.
- Reset mid-conversion aborts immediately. The old display value is lost and the display returns to "0".

Test Plan:
- Reset, release, no strobe: an_o cycles 1110→1101→1011→0111 every 25 clk. seg_o=C0 on digit0, FF on digits 1-3. busy_o=0, ovf_o=0.
- res_i=32'd1234, out_i 0→1 at edge N: busy_o high from N to N+17. At N+17 the digits are 1,2,3,4 and seg_o sequence over a full scan is 99,B0,A4,F9 for digits 0..3.
- res_i=32'd10000 strobe: ovf_o=1 at N+17, all four digits BF. A following strobe with res_i=7 gives ovf_o=0, display F8,FF,FF,FF.
- res_i=32'd0x00010005 (65541): ovf_o=1, display "----". This checks that ovf is decided on all 32 bits, not the low 16.
- Strobes with 42 at N, 9 at N+5 and 77 at N+8: the first conversion shows 42 at N+17. The pending value 77 then loads at N+18 and shows at N+35. 9 is never displayed.
- Strobe 5678, assert rst=0 at N+6: outputs return to reset values immediately with busy_o=0. After release the display shows "0" and no conversion resumes.

Source files
------------

// File: rtl/seg_result_display.sv
// Captures a CPU result on the rising edge of its valid strobe, converts it to
// decimal with a sequential double-dabble and scans it onto a 4-digit display.
module seg_result_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 25,
    parameter int BIN_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] res_i,
    input  logic        out_i,
    output logic [7:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        busy_o,
    output logic        ovf_o
);

    localparam int DIG_BITS = DIGITS * 4;
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int ITER_W   = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(BIN_W - 1);
    localparam logic [31:0]       DEC_MAX   = 32'd9999;
    localparam logic [7:0]        SEG_DASH  = 8'hBF;
    localparam logic [7:0]        SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  out_q_r;
    logic                  req_s;
    logic                  start_s;
    logic [31:0]           load_val_s;
    logic                  pend_r;
    logic [31:0]           pend_val_r;
    logic [BIN_W-1:0]      bin_r;
    logic [DIG_BITS-1:0]   bcd_r;
    logic [DIG_BITS-1:0]   adj_s;
    logic [ITER_W-1:0]     iter_r;
    logic                  ovf_nxt_r;
    logic                  busy_r;
    logic                  ovf_r;
    logic [DIG_BITS-1:0]   digits_r;
    logic [CNT_W-1:0]      scan_cnt_r;
    logic [1:0]            scan_idx_r;
    logic [3:0]            an_r;
    logic [3:0]            cur_digit_s;
    logic [3:0]            hi_nz_s;
    logic [7:0]            seg_s;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3.
    function automatic logic [DIG_BITS-1:0] dabble_adj(input logic [DIG_BITS-1:0] bcd);
        logic [DIG_BITS-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] an_code(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    assign req_s      = out_i & ~out_q_r;
    assign load_val_s = pend_r ? pend_val_r : res_i;
    assign adj_s      = dabble_adj(bcd_r);

    // Strobe edge detector register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q_r <= 1'b0;
        end else begin
            out_q_r <= out_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and conversion start decode.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s || pend_r) begin
                    start_s = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (iter_r == ITER_MAX) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One-deep pending request; a newer request overwrites the held value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r     <= 1'b0;
            pend_val_r <= 32'd0;
        end else if (state_r == IDLE) begin
            // A pending value loads now; a simultaneous new request takes its place.
            pend_r <= pend_r & req_s;
            if (pend_r && req_s) begin
                pend_val_r <= res_i;
            end
        end else if (req_s) begin
            pend_r     <= 1'b1;
            pend_val_r <= res_i;
        end
    end

    // Conversion datapath: load, shift-and-adjust, then commit to the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r     <= {BIN_W{1'b0}};
            bcd_r     <= {DIG_BITS{1'b0}};
            iter_r    <= {ITER_W{1'b0}};
            ovf_nxt_r <= 1'b0;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
            digits_r  <= {DIG_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        bin_r     <= load_val_s[BIN_W-1:0];
                        bcd_r     <= {DIG_BITS{1'b0}};
                        iter_r    <= {ITER_W{1'b0}};
                        ovf_nxt_r <= (load_val_s > DEC_MAX);
                        busy_r    <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {adj_s[DIG_BITS-2:0], bin_r, 1'b0};
                    iter_r         <= iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
                end
                DONE: begin
                    digits_r <= bcd_r;
                    ovf_r    <= ovf_nxt_r;
                    busy_r   <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Digit scan timer, index and digit enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r <= 2'd0;
            an_r       <= 4'b1110;
        end else if (scan_cnt_r == CNT_MAX) begin
            scan_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r <= scan_idx_r + 2'd1;
            an_r       <= an_code(scan_idx_r + 2'd1);
        end else begin
            scan_cnt_r <= scan_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Segment select with overflow dashes and leading-zero blanking.
    always_comb begin
        cur_digit_s = digits_r[{scan_idx_r, 2'b00} +: 4];
        hi_nz_s[3]  = |digits_r[15:12];
        hi_nz_s[2]  = |digits_r[15:8];
        hi_nz_s[1]  = |digits_r[15:4];
        hi_nz_s[0]  = 1'b1;
        if (ovf_r) begin
            seg_s = SEG_DASH;
        end else if (!hi_nz_s[scan_idx_r]) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_code(cur_digit_s);
        end
    end

    assign seg_o  = seg_s;
    assign an_o   = an_r;
    assign busy_o = busy_r;
    assign ovf_o  = ovf_r;

endmodule

// File: tb/tb_seg_result_display.sv
// Directed bench for seg_result_display: reset, scan, conversion latency,
// overflow, pending requests and reset mid-conversion.
`timescale 1ns/1ps
module tb_seg_result_display;

    logic        clk;
    logic        rst;
    logic [31:0] res_i;
    logic        out_i;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic        busy_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    seg_result_display dut (
        .clk    (clk),
        .rst    (rst),
        .res_i  (res_i),
        .out_i  (out_i),
        .seg_o  (seg_o),
        .an_o   (an_o),
        .busy_o (busy_o),
        .ovf_o  (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare seg_o against the expected code of whichever digit is enabled now.
    task automatic check_cur(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp;
        case (an_o)
            4'b1110: exp = e0;
            4'b1101: exp = e1;
            4'b1011: exp = e2;
            4'b0111: exp = e3;
            default: exp = 8'h00;
        endcase
        check(tag, {24'd0, seg_o}, {24'd0, exp});
    endtask

    // Observe one full scan period and compare each digit's segment code.
    task automatic scan_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] seen [4];
        logic [7:0] exp  [4];
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        repeat (100) begin
            @(negedge clk);
            case (an_o)
                4'b1110: seen[0] = seg_o;
                4'b1101: seen[1] = seg_o;
                4'b1011: seen[2] = seg_o;
                4'b0111: seen[3] = seg_o;
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", tag, i), {24'd0, seen[i]}, {24'd0, exp[i]});
        end
    endtask

    // Raise the strobe so edge N samples it; returns just after edge N.
    task automatic strobe(input logic [31:0] v);
        res_i = v;
        out_i = 1'b1;
        @(negedge clk);
        out_i = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        out_i = 1'b0;
        res_i = 32'd0;
        #2 rst = 1'b0;
        #10;
        check("rst_an",   {28'd0, an_o},   {28'd0, 4'b1110});
        check("rst_seg",  {24'd0, seg_o},  {24'd0, 8'hC0});
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ovf",  {31'd0, ovf_o},  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle scan timing
        repeat (24) @(negedge clk);
        check("scan0_an",  {28'd0, an_o},  {28'd0, 4'b1110});
        check("scan0_seg", {24'd0, seg_o}, {24'd0, 8'hC0});
        @(negedge clk);
        check("scan1_an",  {28'd0, an_o},  {28'd0, 4'b1101});
        check("scan1_seg", {24'd0, seg_o}, {24'd0, 8'hFF});
        repeat (25) @(negedge clk);
        check("scan2_an",  {28'd0, an_o},  {28'd0, 4'b1011});
        check("scan2_seg", {24'd0, seg_o}, {24'd0, 8'hFF});
        repeat (25) @(negedge clk);
        check("scan3_an",  {28'd0, an_o},  {28'd0, 4'b0111});
        check("scan3_seg", {24'd0, seg_o}, {24'd0, 8'hFF});
        repeat (25) @(negedge clk);
        check("scan4_an",  {28'd0, an_o},  {28'd0, 4'b1110});
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // 1234: latency and digit order
        strobe(32'd1234);
        check("c1234_busy_n0", {31'd0, busy_o}, 32'd1);
        repeat (16) @(negedge clk);
        check("c1234_busy_n16", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check("c1234_busy_n17", {31'd0, busy_o}, 32'd0);
        check("c1234_ovf",      {31'd0, ovf_o},  32'd0);
        scan_check("c1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // 10000 overflows, then 7 clears it
        strobe(32'd10000);
        repeat (17) @(negedge clk);
        check("c10000_ovf", {31'd0, ovf_o}, 32'd1);
        scan_check("c10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        strobe(32'd7);
        repeat (17) @(negedge clk);
        check("c7_ovf", {31'd0, ovf_o}, 32'd0);
        scan_check("c7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);

        // Overflow decided on all 32 bits (low half alone is 5)
        strobe(32'h0001_0005);
        repeat (16) @(negedge clk);
        check("c65541_ovf_n16", {31'd0, ovf_o}, 32'd0);
        @(negedge clk);
        check("c65541_ovf", {31'd0, ovf_o}, 32'd1);
        scan_check("c65541", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // 42 at N, 9 at N+5, 77 at N+8: only 42 then 77 appear
        strobe(32'd42);
        repeat (4) @(negedge clk);
        res_i = 32'd9;
        out_i = 1'b1;
        @(negedge clk);
        out_i = 1'b0;
        repeat (2) @(negedge clk);
        res_i = 32'd77;
        out_i = 1'b1;
        @(negedge clk);
        out_i = 1'b0;
        check("pend_busy_n8", {31'd0, busy_o}, 32'd1);
        repeat (9) @(negedge clk);
        check("pend_busy_n17", {31'd0, busy_o}, 32'd0);
        check("pend_ovf_n17",  {31'd0, ovf_o},  32'd0);
        check_cur("show42_n17", 8'hA4, 8'h99, 8'hFF, 8'hFF);
        for (int k = 18; k <= 34; k++) begin
            @(negedge clk);
            check_cur($sformatf("show42_n%0d", k), 8'hA4, 8'h99, 8'hFF, 8'hFF);
            if (k == 18 || k == 34) begin
                check($sformatf("pend_busy_n%0d", k), {31'd0, busy_o}, 32'd1);
            end
        end
        @(negedge clk);
        check("pend_busy_n35", {31'd0, busy_o}, 32'd0);
        scan_check("c77", 8'hF8, 8'hF8, 8'hFF, 8'hFF);

        // Reset in the middle of a conversion
        strobe(32'd5678);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_an",   {28'd0, an_o},   {28'd0, 4'b1110});
        check("mid_rst_seg",  {24'd0, seg_o},  {24'd0, 8'hC0});
        check("mid_rst_ovf",  {31'd0, ovf_o},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);
        scan_check("post_rst", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        check("post_rst_busy_end", {31'd0, busy_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
